mux_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a time-division auto-scan mode, replacing the fixed 4:1 single-bit combinational selectors. In manual mode it behaves as an N:1 mux with a one-cycle registered output. In scan mode an internal pointer steps through all channels, dwelling a programmable number of enabled cycles on each. It serves as the front-end sampler for multi-input status and display paths.

---
 rtl/mux_scan_if.sv | 18 +
 rtl/mux_scan.sv | 96 +++++++++
 tb/tb_mux_scan.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Channel bus for mux_scan: packed channel inputs, select/mode/enable in, sample out.
interface mux_scan_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 1,
  parameter int unsigned SW = 2
);
  logic [N*W-1:0] I;
  logic [SW-1:0]  S;
  logic           mode;
  logic           en;
  logic [W-1:0]   F;
  logic [SW-1:0]  ch;
  logic           valid;
  logic           wrap;

  modport master (output I, S, mode, en, input F, ch, valid, wrap);
  modport slave  (input I, S, mode, en, output F, ch, valid, wrap);
endinterface

// File: rtl/mux_scan.sv
// N-channel registered mux with time-division auto-scan; define MUX_SCAN_HOLD_EN to keep
// F/ch on disabled cycles instead of clearing them.
module mux_scan #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned SW    = 2,
  parameter int unsigned DWELL = 1
) (
  input logic       clk,
  input logic       rst,
  mux_scan_if.slave bus
);

  localparam int unsigned DcW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [W-1:0]   f_q, f_d;
  logic [SW-1:0]  ch_q, ch_d;
  logic           valid_q, valid_d;
  logic           wrap_q, wrap_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [DcW-1:0] dc_q, dc_d;

  logic [SW-1:0]  sel;
  logic [W-1:0]   sel_data;
  logic           last_ch;
  logic           last_dw;

  assign sel     = bus.mode ? ptr_q : bus.S;
  assign last_ch = (ptr_q == SW'(N - 1));
  assign last_dw = (dc_q == DcW'(DWELL - 1));

  // Selects beyond N-1 (non-power-of-2 N) fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SW'(k)) sel_data = bus.I[k*W +: W];
    end
  end

  always_comb begin
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    ptr_d   = ptr_q;
    dc_d    = dc_q;
`ifdef MUX_SCAN_HOLD_EN
    f_d     = f_q;
    ch_d    = ch_q;
`else
    f_d     = '0;
    ch_d    = '0;
`endif
    // Manual mode parks the scan so the next scan always starts at channel 0.
    if (!bus.mode) begin
      ptr_d = '0;
      dc_d  = '0;
    end
    if (bus.en) begin
      f_d     = sel_data;
      ch_d    = sel;
      valid_d = 1'b1;
      if (bus.mode) begin
        wrap_d = last_ch && last_dw;
        if (last_dw) begin
          dc_d  = '0;
          ptr_d = last_ch ? '0 : ptr_q + SW'(1);
        end else begin
          dc_d  = dc_q + DcW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      dc_q    <= '0;
    end else begin
      f_q     <= f_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      dc_q    <= dc_d;
    end
  end

  assign bus.F     = f_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: a 4-channel/DWELL=1 instance and a 3-channel/DWELL=2 instance.
module tb_mux_scan;

  typedef struct packed {
    logic [7:0] f;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

`ifdef MUX_SCAN_HOLD_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  string step = "reset";

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  mux_scan_if #(.N(4), .W(8), .SW(2)) bus_a ();
  mux_scan_if #(.N(3), .W(8), .SW(2)) bus_b ();

  mux_scan #(.N(4), .W(8), .SW(2), .DWELL(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_scan #(.N(3), .W(8), .SW(2), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  function automatic exp_t mk(int f, int ch, bit v, bit w);
    exp_t e;
    e.f     = 8'(f);
    e.ch    = 2'(ch);
    e.valid = v;
    e.wrap  = w;
    return e;
  endfunction

  function automatic exp_t obs_a();
    return exp_t'({bus_a.F, bus_a.ch, bus_a.valid, bus_a.wrap});
  endfunction

  function automatic exp_t obs_b();
    return exp_t'({bus_b.F, bus_b.ch, bus_b.valid, bus_b.wrap});
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed f=%h ch=%0d valid=%b wrap=%b, expected f=%h ch=%0d valid=%b wrap=%b",
             step, tag, obs.f, obs.ch, obs.valid, obs.wrap, exp.f, exp.ch, exp.valid, exp.wrap);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge against the scoreboards.
  task automatic tick();
    @(posedge clk);
    #1;
    if (q_a.size() > 0) check("a", obs_a(), q_a.pop_front());
    if (q_b.size() > 0) check("b", obs_b(), q_b.pop_front());
  endtask

  initial begin
    int c;
    bus_a.I = {8'h01, 8'h00, 8'h01, 8'h00};
    bus_a.S = '0;  bus_a.mode = 1'b0;  bus_a.en = 1'b0;
    bus_b.I = {8'h33, 8'h22, 8'h11};
    bus_b.S = '0;  bus_b.mode = 1'b0;  bus_b.en = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("a", obs_a(), mk(0, 0, 0, 0));
    check("b", obs_b(), mk(0, 0, 0, 0));
    rst = 1'b0;

    // Manual 4:1 with 1010 pattern
    step = "manual";
    bus_a.en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bus_a.S = 2'(s);
      q_a.push_back(mk(s % 2, s, 1, 0));
      tick();
    end

    // Scan, DWELL=1: two full passes, wrap only on channel 3
    step = "scan_a";
    bus_a.I = {8'h44, 8'h33, 8'h22, 8'h11};
    bus_a.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = i % 4;
      q_a.push_back(mk(8'h11 * (c + 1), c, 1, c == 3));
      tick();
    end
    bus_a.mode = 1'b0;
    bus_a.en = 1'b0;

    // Scan, N=3 DWELL=2: wrap on second channel-2 sample only
    step = "scan_b";
    bus_b.mode = 1'b1;
    bus_b.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      c = (i / 2) % 3;
      q_b.push_back(mk(8'h11 * (c + 1), c, 1, i == 5));
      tick();
    end

    // Manual select beyond N-1 reads zero
    step = "manual_oob";
    bus_b.mode = 1'b0;
    bus_b.S = 2'd3;
    q_b.push_back(mk(0, 3, 1, 0));
    tick();

    // Pause after the last channel-1 sample, then resume at channel 2
    step = "pause";
    bus_b.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = i / 2;
      q_b.push_back(mk(8'h11 * (c + 1), c, 1, 0));
      tick();
    end
    bus_b.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q_b.push_back(Hold ? mk(8'h22, 1, 0, 0) : mk(0, 0, 0, 0));
      tick();
    end
    step = "resume";
    bus_b.en = 1'b1;
    q_b.push_back(mk(8'h33, 2, 1, 0));
    tick();
    q_b.push_back(mk(8'h33, 2, 1, 1));
    tick();

    // One disabled manual cycle mid-dwell restarts both pointer and dwell counter
    step = "dc_restart";
    q_b.push_back(mk(8'h11, 0, 1, 0));
    tick();
    bus_b.mode = 1'b0;
    bus_b.en = 1'b0;
    q_b.push_back(Hold ? mk(8'h11, 0, 0, 0) : mk(0, 0, 0, 0));
    tick();
    bus_b.mode = 1'b1;
    bus_b.en = 1'b1;
    q_b.push_back(mk(8'h11, 0, 1, 0));
    tick();
    q_b.push_back(mk(8'h11, 0, 1, 0));
    tick();
    q_b.push_back(mk(8'h22, 1, 1, 0));
    tick();
    bus_b.en = 1'b0;

    // Asynchronous reset between edges mid-scan
    step = "async_rst";
    bus_a.mode = 1'b1;
    bus_a.en = 1'b1;
    q_a.push_back(mk(8'h11, 0, 1, 0));
    tick();
    q_a.push_back(mk(8'h22, 1, 1, 0));
    tick();
    #2 rst = 1'b1;
    #1;
    check("a_now", obs_a(), mk(0, 0, 0, 0));
    rst = 1'b0;
    q_a.push_back(mk(8'h11, 0, 1, 0));
    tick();
    q_a.push_back(mk(8'h22, 1, 1, 0));
    tick();
    q_a.push_back(mk(8'h33, 2, 1, 0));
    tick();

    // Manual idle cycle then back to scan: restarts at channel 0
    step = "mode_return";
    bus_a.mode = 1'b0;
    bus_a.en = 1'b0;
    q_a.push_back(Hold ? mk(8'h33, 2, 0, 0) : mk(0, 0, 0, 0));
    tick();
    bus_a.mode = 1'b1;
    bus_a.en = 1'b1;
    q_a.push_back(mk(8'h11, 0, 1, 0));
    tick();
    q_a.push_back(mk(8'h22, 1, 1, 0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
